regbank_write_arbiter: RTL and testbench

//  Shares the register bank's single write port (Sel_C/Data_C) among NREQ requesters
//  (default: 0 = ALU writeback, 1 = memory load to W, 2 = I/O/debug loader).

---
 rtl/regbank_write_arbiter.sv | 162 ++++++++++++++++
 tb/tb_regbank_write_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/regbank_write_arbiter.sv
// Round-robin arbiter sharing the register bank write port (Sel_C/Data_C) among NREQ
// requesters, with a bounded burst lock and filtering of writes to non-writable selects.
module regbank_write_arbiter #(
    parameter int         NREQ     = 3,
    parameter int         LOCK_MAX = 4,
    parameter logic [5:0] IDLE_SEL = 6'd63
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      i_req,
    input  logic [NREQ-1:0]      i_lock,
    input  logic [NREQ*6-1:0]    i_sel,
    input  logic [NREQ*16-1:0]   i_data,
    output logic [NREQ-1:0]      o_gnt,
    output logic [5:0]           o_wr_sel,
    output logic [15:0]          o_wr_data,
    output logic                 o_wr_en,
    output logic                 o_err,
    output logic [2:0]           o_err_id
);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_LOCKED  = 1'b1;
    localparam logic [3:0] LOCK_MAX_C = 4'(LOCK_MAX);
    localparam logic       LOCK_EN    = (LOCK_MAX > 1);

    logic [0:0]      r_state;
    logic [2:0]      r_ptr;
    logic [2:0]      r_owner;
    logic [3:0]      r_lock_cnt;
    logic [5:0]      r_wr_sel;
    logic [15:0]     r_wr_data;
    logic            r_wr_en;
    logic            r_err;
    logic [2:0]      r_err_id;

    logic            w_owner_req;
    logic            w_gnt_valid;
    logic [2:0]      w_gnt_idx;
    logic [NREQ-1:0] w_gnt;
    logic [5:0]      w_sel_k;
    logic [15:0]     w_data_k;
    logic            w_lock_k;
    logic [2:0]      w_next_ptr;

    // Bank decodes 28, 29, 32, 33 and 35..63 to nothing writable; 34 is the W register.
    function automatic logic sel_legal(input logic [5:0] s);
        return (s <= 6'd27) || (s == 6'd30) || (s == 6'd31) || (s == 6'd34);
    endfunction

    // Whether the current lock owner is requesting.
    always_comb begin
        w_owner_req = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            w_owner_req = w_owner_req | (i_req[k] & (3'(k) == r_owner));
        end
    end

    // Grant selection: locked owner first, otherwise cyclic search from the pointer.
    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_idx   = 3'd0;
        if (reset) begin
            w_gnt_valid = 1'b0;
        end else if ((r_state == ST_LOCKED) && w_owner_req) begin
            w_gnt_valid = 1'b1;
            w_gnt_idx   = r_owner;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                for (int k = 0; k < NREQ; k++) begin
                    w_gnt_idx   = (!w_gnt_valid && i_req[k] &&
                                   (3'(k) == 3'((int'(r_ptr) + i) % NREQ))) ? 3'(k) : w_gnt_idx;
                    w_gnt_valid = w_gnt_valid | (i_req[k] &&
                                   (3'(k) == 3'((int'(r_ptr) + i) % NREQ)));
                end
            end
        end
    end

    // One-hot grant and mux of the granted requester's sel/data/lock.
    always_comb begin
        w_gnt    = '0;
        w_sel_k  = 6'd0;
        w_data_k = 16'd0;
        w_lock_k = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            w_gnt[k] = w_gnt_valid & (w_gnt_idx == 3'(k));
            w_sel_k  = w_sel_k  | ({6{w_gnt[k]}}  & i_sel[6*k +: 6]);
            w_data_k = w_data_k | ({16{w_gnt[k]}} & i_data[16*k +: 16]);
            w_lock_k = w_lock_k | (w_gnt[k] & i_lock[k]);
        end
        w_next_ptr = 3'((int'(w_gnt_idx) + 1) % NREQ);
    end

    assign o_gnt = w_gnt;

    // Arbitration state: pointer, lock owner and burst length.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_ptr      <= 3'd0;
            r_owner    <= 3'd0;
            r_lock_cnt <= 4'd0;
        end else if (w_gnt_valid) begin
            if ((r_state == ST_LOCKED) && (w_gnt_idx == r_owner)) begin
                if (!w_lock_k || ((r_lock_cnt + 4'd1) == LOCK_MAX_C)) begin
                    r_state    <= ST_IDLE;
                    r_ptr      <= w_next_ptr;
                    r_lock_cnt <= 4'd0;
                end else begin
                    r_lock_cnt <= r_lock_cnt + 4'd1;
                end
            end else begin
                // Covers IDLE and a locked owner that went quiet this cycle.
                r_ptr <= w_next_ptr;
                if (w_lock_k && LOCK_EN) begin
                    r_state    <= ST_LOCKED;
                    r_owner    <= w_gnt_idx;
                    r_lock_cnt <= 4'd1;
                end else begin
                    r_state    <= ST_IDLE;
                    r_lock_cnt <= 4'd0;
                end
            end
        end else begin
            r_state    <= ST_IDLE;
            r_lock_cnt <= 4'd0;
        end
    end

    // Registered bank write port and error reporting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_sel  <= IDLE_SEL;
            r_wr_data <= 16'd0;
            r_wr_en   <= 1'b0;
            r_err     <= 1'b0;
            r_err_id  <= 3'd0;
        end else if (w_gnt_valid && sel_legal(w_sel_k)) begin
            r_wr_sel  <= w_sel_k;
            r_wr_data <= w_data_k;
            r_wr_en   <= 1'b1;
            r_err     <= 1'b0;
        end else if (w_gnt_valid) begin
            r_wr_sel  <= IDLE_SEL;
            r_wr_en   <= 1'b0;
            r_err     <= 1'b1;
            r_err_id  <= w_gnt_idx;
        end else begin
            r_wr_sel  <= IDLE_SEL;
            r_wr_en   <= 1'b0;
            r_err     <= 1'b0;
        end
    end

    assign o_wr_sel  = r_wr_sel;
    assign o_wr_data = r_wr_data;
    assign o_wr_en   = r_wr_en;
    assign o_err     = r_err;
    assign o_err_id  = r_err_id;

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Directed self-checking bench for regbank_write_arbiter (NREQ=3, LOCK_MAX=4, IDLE_SEL=63).
module tb_regbank_write_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  req = 3'b000;
    logic [2:0]  lock = 3'b000;
    logic [5:0]  tb_sel [3];
    logic [15:0] tb_data [3];
    logic [17:0] sel_bus;
    logic [47:0] data_bus;
    logic [2:0]  gnt;
    logic [5:0]  wr_sel;
    logic [15:0] wr_data;
    logic        wr_en;
    logic        err;
    logic [2:0]  err_id;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    assign sel_bus  = {tb_sel[2], tb_sel[1], tb_sel[0]};
    assign data_bus = {tb_data[2], tb_data[1], tb_data[0]};

    regbank_write_arbiter #(.NREQ(3), .LOCK_MAX(4), .IDLE_SEL(6'd63)) dut (
        .clk(clk), .reset(reset), .i_req(req), .i_lock(lock),
        .i_sel(sel_bus), .i_data(data_bus), .o_gnt(gnt),
        .o_wr_sel(wr_sel), .o_wr_data(wr_data), .o_wr_en(wr_en),
        .o_err(err), .o_err_id(err_id)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        req = 3'b000; lock = 3'b000; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic set_default_sels();
        tb_sel[0] = 6'd10; tb_data[0] = 16'hA000;
        tb_sel[1] = 6'd30; tb_data[1] = 16'hB111;
        tb_sel[2] = 6'd34; tb_data[2] = 16'hC222;
    endtask

    task automatic test_reset();
        req = 3'b111;
        @(posedge clk); @(posedge clk); #1;
        total_cnt++; if (gnt !== 3'b000) $display("FAIL t1_gnt got %b want 000", gnt); else pass_cnt++;
        total_cnt++; if (wr_sel !== 6'd63) $display("FAIL t1_wr_sel got %0d want 63", wr_sel); else pass_cnt++;
        total_cnt++; if (wr_en !== 1'b0) $display("FAIL t1_wr_en got %b want 0", wr_en); else pass_cnt++;
        total_cnt++; if (err !== 1'b0) $display("FAIL t1_err got %b want 0", err); else pass_cnt++;
        total_cnt++; if (err_id !== 3'd0) $display("FAIL t1_err_id got %0d want 0", err_id); else pass_cnt++;
        total_cnt++; if (wr_data !== 16'h0000) $display("FAIL t1_wr_data got %h want 0000", wr_data); else pass_cnt++;
        req = 3'b000;
        reset = 1'b0;
    endtask

    task automatic test_single();
        tb_sel[0] = 6'd5; tb_data[0] = 16'h1234;
        req = 3'b001; #1;
        total_cnt++; if (gnt !== 3'b001) $display("FAIL t2_gnt got %b want 001", gnt); else pass_cnt++;
        @(posedge clk); #1;
        req = 3'b000;
        total_cnt++; if (wr_en !== 1'b1) $display("FAIL t2_wr_en got %b want 1", wr_en); else pass_cnt++;
        total_cnt++; if (wr_sel !== 6'd5) $display("FAIL t2_wr_sel got %0d want 5", wr_sel); else pass_cnt++;
        total_cnt++; if (wr_data !== 16'h1234) $display("FAIL t2_wr_data got %h want 1234", wr_data); else pass_cnt++;
        #1;
        total_cnt++; if (gnt !== 3'b000) $display("FAIL t2_idle_gnt got %b want 000", gnt); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if (wr_sel !== 6'd63) $display("FAIL t2_idle_sel got %0d want 63", wr_sel); else pass_cnt++;
        total_cnt++; if (wr_en !== 1'b0) $display("FAIL t2_idle_en got %b want 0", wr_en); else pass_cnt++;
        total_cnt++; if (wr_data !== 16'h1234) $display("FAIL t2_data_hold got %h want 1234", wr_data); else pass_cnt++;
    endtask

    task automatic test_round_robin();
        logic [5:0]  es [3];
        logic [15:0] ed [3];
        logic [2:0]  eg;
        es = '{6'd10, 6'd30, 6'd34};
        ed = '{16'hA000, 16'hB111, 16'hC222};
        do_reset();
        set_default_sels();
        req = 3'b111;
        for (int c = 0; c < 6; c++) begin
            eg = 3'b001 << (c % 3);
            #1;
            total_cnt++; if (gnt !== eg) $display("FAIL t3_gnt[%0d] got %b want %b", c, gnt, eg); else pass_cnt++;
            @(posedge clk); #1;
            total_cnt++; if (wr_sel !== es[c % 3] || wr_data !== ed[c % 3] || wr_en !== 1'b1)
                $display("FAIL t3_write[%0d] got sel=%0d data=%h en=%b want sel=%0d data=%h en=1",
                         c, wr_sel, wr_data, wr_en, es[c % 3], ed[c % 3]);
            else pass_cnt++;
        end
        req = 3'b000;
    endtask

    task automatic test_lock_then_reset();
        int         ord [7];
        logic [5:0] es [3];
        logic [2:0] eg;
        ord = '{1, 1, 1, 1, 2, 0, 1};
        es  = '{6'd10, 6'd30, 6'd34};
        // pointer is 0 after the round-robin run; one req0 transfer moves it to 1
        req = 3'b001;
        @(posedge clk); #1;
        req = 3'b111; lock = 3'b010;
        for (int c = 0; c < 7; c++) begin
            eg = 3'b001 << ord[c];
            #1;
            total_cnt++; if (gnt !== eg) $display("FAIL t4_gnt[%0d] got %b want %b", c, gnt, eg); else pass_cnt++;
            @(posedge clk); #1;
            total_cnt++; if (wr_sel !== es[ord[c]]) $display("FAIL t4_sel[%0d] got %0d want %0d", c, wr_sel, es[ord[c]]); else pass_cnt++;
        end
        // now locked by requester 1 with a live write on the port; reset asynchronously
        #2; reset = 1'b1; #1;
        total_cnt++; if (wr_en !== 1'b0) $display("FAIL t6_wr_en got %b want 0", wr_en); else pass_cnt++;
        total_cnt++; if (wr_sel !== 6'd63) $display("FAIL t6_wr_sel got %0d want 63", wr_sel); else pass_cnt++;
        total_cnt++; if (gnt !== 3'b000) $display("FAIL t6_gnt got %b want 000", gnt); else pass_cnt++;
        @(posedge clk); #1;
        reset = 1'b0; lock = 3'b000; #1;
        total_cnt++; if (gnt !== 3'b001) $display("FAIL t6_first_gnt got %b want 001", gnt); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if (wr_sel !== 6'd10) $display("FAIL t6_first_sel got %0d want 10", wr_sel); else pass_cnt++;
        req = 3'b000;
    endtask

    task automatic test_illegal_sel();
        logic [5:0] bsel [10];
        logic       blegal [10];
        logic [5:0] exp_sel;
        bsel   = '{6'd27, 6'd28, 6'd29, 6'd30, 6'd31, 6'd32, 6'd33, 6'd34, 6'd35, 6'd63};
        blegal = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        do_reset();
        tb_sel[2] = 6'd28; tb_data[2] = 16'hDEAD;
        req = 3'b100; #1;
        total_cnt++; if (gnt !== 3'b100) $display("FAIL t5_gnt got %b want 100", gnt); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if (err !== 1'b1) $display("FAIL t5_err got %b want 1", err); else pass_cnt++;
        total_cnt++; if (err_id !== 3'd2) $display("FAIL t5_err_id got %0d want 2", err_id); else pass_cnt++;
        total_cnt++; if (wr_en !== 1'b0) $display("FAIL t5_wr_en got %b want 0", wr_en); else pass_cnt++;
        total_cnt++; if (wr_sel !== 6'd63) $display("FAIL t5_wr_sel got %0d want 63", wr_sel); else pass_cnt++;
        for (int i = 0; i < 10; i++) begin
            tb_sel[2] = bsel[i];
            exp_sel = blegal[i] ? bsel[i] : 6'd63;
            @(posedge clk); #1;
            total_cnt++; if (wr_en !== blegal[i] || wr_sel !== exp_sel || err !== !blegal[i])
                $display("FAIL sel_boundary[%0d] got en=%b sel=%0d err=%b want en=%b sel=%0d err=%b",
                         bsel[i], wr_en, wr_sel, err, blegal[i], exp_sel, !blegal[i]);
            else pass_cnt++;
        end
        req = 3'b000;
        @(posedge clk); #1;
        total_cnt++; if (err !== 1'b0 || err_id !== 3'd2)
            $display("FAIL t5_err_hold got err=%b id=%0d want err=0 id=2", err, err_id);
        else pass_cnt++;
    endtask

    task automatic test_owner_drop();
        do_reset();
        set_default_sels();
        req = 3'b010; lock = 3'b010; #1;
        total_cnt++; if (gnt !== 3'b010) $display("FAIL od_first_gnt got %b want 010", gnt); else pass_cnt++;
        @(posedge clk); #1;
        // locked by 1, pointer at 2: owner still wins
        req = 3'b111; #1;
        total_cnt++; if (gnt !== 3'b010) $display("FAIL od_owner_prio got %b want 010", gnt); else pass_cnt++;
        @(posedge clk); #1;
        req = 3'b101; lock = 3'b000; #1;
        total_cnt++; if (gnt !== 3'b100) $display("FAIL od_drop_gnt got %b want 100", gnt); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if (wr_sel !== 6'd34 || wr_data !== 16'hC222)
            $display("FAIL od_drop_write got sel=%0d data=%h want sel=34 data=c222", wr_sel, wr_data);
        else pass_cnt++;
        #1;
        total_cnt++; if (gnt !== 3'b001) $display("FAIL od_next_gnt got %b want 001", gnt); else pass_cnt++;
        req = 3'b000;
        @(posedge clk); #1;
    endtask

    task automatic test_withdraw();
        do_reset();
        set_default_sels();
        req = 3'b011; #1;
        total_cnt++; if (gnt !== 3'b001) $display("FAIL wd_gnt got %b want 001", gnt); else pass_cnt++;
        @(posedge clk); #1;
        req = 3'b001; #1;
        total_cnt++; if (gnt !== 3'b001) $display("FAIL wd_gnt2 got %b want 001", gnt); else pass_cnt++;
        @(posedge clk); #1;
        req = 3'b000;
        total_cnt++; if (wr_sel !== 6'd10) $display("FAIL wd_sel got %0d want 10", wr_sel); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if (wr_en !== 1'b0 || wr_sel !== 6'd63)
            $display("FAIL wd_idle got en=%b sel=%0d want en=0 sel=63", wr_en, wr_sel);
        else pass_cnt++;
    endtask

    initial begin
        set_default_sels();
        test_reset();
        test_single();
        test_round_robin();
        test_lock_then_reset();
        test_illegal_sel();
        test_owner_drop();
        test_withdraw();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
